interfaz_memoria: RTL
=====================

INTERFAZ_MEMORIA -- requirements
Module: interfaz_memoria

Interface
REQ-001 SHALL have parameter ANCHO_DIR, default 16, memory address width.
REQ-002 SHALL have parameter ANCHO_DATO, default 16, data word width.
REQ-003 SHALL have parameter CICLOS_LIMITE, default 15, timeout cycle count, range 1..255.
REQ-004 Reloj  in  1  single clock, all state on rising edge.
REQ-005 Reiniciar  in  1  reset, asynchronous, active-low.
REQ-006 Peticion  in  1  one-cycle access request from control unit.
REQ-007 Escribir  in  1  access type, 1=write, 0=read, sampled with Peticion.
REQ-008 Direccion  in  ANCHO_DIR  address from AR, sampled with Peticion.
REQ-009 DatoEscritura  in  ANCHO_DATO  write data from DR, sampled with Peticion.
REQ-010 DatoLectura  out  ANCHO_DATO  registered read data toward DR.
REQ-011 Listo  out  1  one-cycle completion pulse.
REQ-012 Error  out  1  one-cycle timeout pulse, coincident with Listo.
REQ-013 Ocupado  out  1  high whenever state is not REPOSO.
REQ-014 MemSel  out  1  memory chip select.
REQ-015 MemEsc  out  1  memory write enable, valid while MemSel=1.
REQ-016 MemDir / MemDatoSal  out  ANCHO_DIR / ANCHO_DATO  registered address and write data.
REQ-017 MemDatoEnt  in  ANCHO_DATO  memory read data; MemListo  in  1  memory acknowledge.

Function
REQ-018 SHALL implement a three-state FSM: REPOSO, ACCESO, FIN.
REQ-019 REPOSO: Peticion=1 at edge -> latch Escribir/Direccion/DatoEscritura, go ACCESO.
REQ-020 ACCESO: MemSel=1, MemEsc=latched Escribir, MemDir/MemDatoSal=latched values, all stable for the whole state.
REQ-021 ACCESO: MemListo=1 at edge -> go FIN; on read, DatoLectura<=MemDatoEnt at the same edge; on write, DatoLectura unchanged.
REQ-022 FIN: MemSel=0, Listo=1 for exactly one cycle, unconditional next state REPOSO.
REQ-023 Minimum latency: Peticion at edge N, MemListo at edge N+1, Listo high in cycle after N+1, Ocupado low after N+2.
REQ-024 Peticion while Ocupado=1 (ACCESO or FIN) SHALL be ignored and not queued.
REQ-025 MemListo outside ACCESO SHALL be ignored.
REQ-026 Listo and Error SHALL never be high outside FIN.

Reset
REQ-027 Reiniciar=0 SHALL asynchronously force state REPOSO, MemSel=0, MemEsc=0, Listo=0, Error=0, Ocupado=0, DatoLectura/MemDir/MemDatoSal=0, timeout counter=0.
REQ-028 Reset during ACCESO SHALL abandon the access with no Listo; first request is accepted at the first edge after release.

Configuration
REQ-029 Macro MEM_TIMEOUT_EN defined: counter clears on entry to ACCESO and increments each ACCESO cycle; at CICLOS_LIMITE without MemListo -> FIN with Listo=1 and Error=1; read timeout loads DatoLectura with all ones.
REQ-030 Timeout and MemListo at the same edge: MemListo wins, Error=0, data captured.
REQ-031 Macro MEM_TIMEOUT_EN undefined: no counter; ACCESO waits indefinitely; Error tied 0.

Structure
REQ-032 Shared package paquete_memoria SHALL hold state encodings (REPOSO=2'b00, ACCESO=2'b01, FIN=2'b10) and default width constants.
REQ-033 Timeout counter SHALL be sub-module contador_espera, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-034 Read: Peticion, Escribir=0, Direccion=16'h00A5; MemListo after 3 cycles with MemDatoEnt=16'h1234 -> MemDir=16'h00A5, DatoLectura=16'h1234, one Listo pulse.
REQ-035 Write: Direccion=16'h0010, DatoEscritura=16'hBEEF, MemListo on first ACCESO cycle -> MemEsc=1, MemDatoSal=16'hBEEF, Listo at cycle N+2, DatoLectura unchanged.
REQ-036 Busy drop: second Peticion during ACCESO with Direccion=16'h0002 -> MemDir stays at first address, exactly one Listo.
REQ-037 Timeout (MEM_TIMEOUT_EN, CICLOS_LIMITE=4): read, MemListo never asserted -> Listo=Error=1 after 4 ACCESO cycles, DatoLectura=16'hFFFF; MemListo at edge 4 -> Error=0.
REQ-038 Reset mid-ACCESO: Reiniciar=0 -> MemSel falls immediately without clock, no Listo; new request after release completes normally.

Source files
------------

// File: rtl/interfaz_memoria_pkg.sv
// Shared definitions for the memory interface: FSM state encodings and
// default width/limit constants. Used with or without MEM_TIMEOUT_EN.
package paquete_memoria;

  localparam int ANCHO_DIR_DEF     = 16;
  localparam int ANCHO_DATO_DEF    = 16;
  localparam int CICLOS_LIMITE_DEF = 15;
  localparam int ANCHO_CUENTA      = 8;

  typedef enum logic [1:0] {
    REPOSO = 2'b00,
    ACCESO = 2'b01,
    FIN    = 2'b10
  } estado_t;

endpackage

// File: rtl/interfaz_memoria_if.sv
// Bus bundle between the control unit, the memory interface and the memory.
// The slave modport is the interfaz_memoria view; master is the view of
// whatever drives requests and models the memory.
//
// Handshake: Peticion is a one-cycle request sampled only while idle
// (Ocupado=0); requests seen while Ocupado=1 are dropped. The block answers
// with a one-cycle Listo pulse (Error coincident on timeout). Toward memory,
// MemSel/MemEsc/MemDir/MemDatoSal stay stable until MemListo is seen at a
// rising edge while MemSel=1; MemListo at any other time is ignored.
interface interfaz_memoria_if
  import paquete_memoria::*;
#(
  parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter int ANCHO_DATO = ANCHO_DATO_DEF
) ();

  logic                  Peticion;
  logic                  Escribir;
  logic [ANCHO_DIR-1:0]  Direccion;
  logic [ANCHO_DATO-1:0] DatoEscritura;
  logic [ANCHO_DATO-1:0] DatoLectura;
  logic                  Listo;
  logic                  Error;
  logic                  Ocupado;
  logic                  MemSel;
  logic                  MemEsc;
  logic [ANCHO_DIR-1:0]  MemDir;
  logic [ANCHO_DATO-1:0] MemDatoSal;
  logic [ANCHO_DATO-1:0] MemDatoEnt;
  logic                  MemListo;

  modport slave (
    input  Peticion, Escribir, Direccion, DatoEscritura, MemDatoEnt, MemListo,
    output DatoLectura, Listo, Error, Ocupado, MemSel, MemEsc, MemDir, MemDatoSal
  );

  modport master (
    output Peticion, Escribir, Direccion, DatoEscritura, MemDatoEnt, MemListo,
    input  DatoLectura, Listo, Error, Ocupado, MemSel, MemEsc, MemDir, MemDatoSal
  );

endinterface

// File: rtl/interfaz_memoria_contador_espera.sv
// Access timeout counter. Cleared while limpiar is high, counts every cycle
// contar is high; expirado flags the edge that completes the CICLOS_LIMITE-th
// counted cycle. Only instantiated when MEM_TIMEOUT_EN is defined.
module contador_espera
  import paquete_memoria::*;
#(
  parameter int CICLOS_LIMITE = CICLOS_LIMITE_DEF
) (
  input  logic reloj,
  input  logic reiniciar_n,
  input  logic limpiar,
  input  logic contar,
  output logic expirado
);

  localparam logic [ANCHO_CUENTA-1:0] ULTIMO = ANCHO_CUENTA'(CICLOS_LIMITE - 1);

  logic [ANCHO_CUENTA-1:0] cuenta_q;
  logic [ANCHO_CUENTA-1:0] cuenta_d;

  // Counter register.
  always_ff @(posedge reloj or negedge reiniciar_n) begin
    if (!reiniciar_n) cuenta_q <= '0;
    else              cuenta_q <= cuenta_d;
  end

  // Clear has priority; the FSM leaves ACCESO at expiry so no wrap occurs.
  always_comb begin
    cuenta_d = cuenta_q;
    if (limpiar)     cuenta_d = '0;
    else if (contar) cuenta_d = cuenta_q + 1'b1;
  end

  // Expiry: the cycle being counted now is the last one allowed.
  always_comb begin
    expirado = contar && (cuenta_q == ULTIMO);
  end

endmodule

// File: rtl/interfaz_memoria.sv
// Single-request memory interface: REPOSO -> ACCESO -> FIN.
// Latches a request, holds the memory bus stable until MemListo, returns
// read data and a one-cycle Listo pulse. Optional access timeout is enabled
// with the macro MEM_TIMEOUT_EN (Error pulse, read data forced to all ones).
module interfaz_memoria
  import paquete_memoria::*;
#(
  parameter int ANCHO_DIR     = ANCHO_DIR_DEF,
  parameter int ANCHO_DATO    = ANCHO_DATO_DEF,
  parameter int CICLOS_LIMITE = CICLOS_LIMITE_DEF
) (
  input  logic                Reloj,
  input  logic                Reiniciar,
  interfaz_memoria_if.slave   bus,
  output estado_t             estado_dbg
);

  if (CICLOS_LIMITE < 1 || CICLOS_LIMITE > 255) begin : g_limite_invalido
    $error("interfaz_memoria: CICLOS_LIMITE must be in 1..255");
  end

  estado_t               estado_q, estado_d;
  logic                  esc_q, esc_d;
  logic [ANCHO_DIR-1:0]  dir_q, dir_d;
  logic [ANCHO_DATO-1:0] dato_sal_q, dato_sal_d;
  logic [ANCHO_DATO-1:0] dato_lec_q, dato_lec_d;

`ifdef MEM_TIMEOUT_EN
  logic error_q, error_d;
  logic expirado;

  // Counter runs only inside ACCESO and is held clear everywhere else, so it
  // starts from zero on every entry to ACCESO.
  contador_espera #(
    .CICLOS_LIMITE (CICLOS_LIMITE)
  ) u_contador_espera (
    .reloj       (Reloj),
    .reiniciar_n (Reiniciar),
    .limpiar     (estado_q != ACCESO),
    .contar      (estado_q == ACCESO),
    .expirado    (expirado)
  );
`endif

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge Reloj or negedge Reiniciar) begin
    if (!Reiniciar) begin
      estado_q   <= REPOSO;
      esc_q      <= 1'b0;
      dir_q      <= '0;
      dato_sal_q <= '0;
      dato_lec_q <= '0;
`ifdef MEM_TIMEOUT_EN
      error_q    <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      esc_q      <= esc_d;
      dir_q      <= dir_d;
      dato_sal_q <= dato_sal_d;
      dato_lec_q <= dato_lec_d;
`ifdef MEM_TIMEOUT_EN
      error_q    <= error_d;
`endif
    end
  end

  // Next state and datapath updates; MemListo wins over a same-edge timeout.
  always_comb begin
    estado_d   = estado_q;
    esc_d      = esc_q;
    dir_d      = dir_q;
    dato_sal_d = dato_sal_q;
    dato_lec_d = dato_lec_q;
`ifdef MEM_TIMEOUT_EN
    error_d    = error_q;
`endif
    case (estado_q)
      REPOSO: begin
        if (bus.Peticion) begin
          estado_d   = ACCESO;
          esc_d      = bus.Escribir;
          dir_d      = bus.Direccion;
          dato_sal_d = bus.DatoEscritura;
        end
      end
      ACCESO: begin
        if (bus.MemListo) begin
          estado_d = FIN;
          if (!esc_q) dato_lec_d = bus.MemDatoEnt;
`ifdef MEM_TIMEOUT_EN
          error_d  = 1'b0;
        end else if (expirado) begin
          estado_d = FIN;
          error_d  = 1'b1;
          if (!esc_q) dato_lec_d = '1;
`endif
        end
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // Outputs decoded from registered state so reset clears them immediately.
  always_comb begin
    bus.MemSel      = (estado_q == ACCESO);
    bus.MemEsc      = (estado_q == ACCESO) && esc_q;
    bus.MemDir      = dir_q;
    bus.MemDatoSal  = dato_sal_q;
    bus.DatoLectura = dato_lec_q;
    bus.Listo       = (estado_q == FIN);
    bus.Ocupado     = (estado_q != REPOSO);
`ifdef MEM_TIMEOUT_EN
    bus.Error       = (estado_q == FIN) && error_q;
`else
    bus.Error       = 1'b0;
`endif
    estado_dbg      = estado_q;
  end

endmodule
